// File: rtl/fifo_sync.sv
// Single-clock FIFO with power-of-two depth, programmable almost-full/almost-empty
// thresholds, standard or first-word-fall-through read mode, and error pulses.
module fifo_sync #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Handshake: wr_en/rd_en are requests; a request is accepted only when the
  // registered full/empty flag of the current cycle allows it, otherwise it is
  // dropped and reported one cycle later on overflow/underflow.

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_nxt;

  assign w_wr_acc    = wr_en & ~r_full  & ~sys_rst;
  assign w_rd_acc    = rd_en & ~r_empty & ~sys_rst;
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  // Storage is never cleared; reset only discards it through the pointers.
  always_ff @(posedge sys_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_af         <= 1'b0;
      r_ae         <= 1'b1;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_count      <= w_count_nxt;
      // Flags come from the next count so they always agree with data_count.
      r_full       <= (w_count_nxt == FULL_C);
      r_empty      <= (w_count_nxt == '0);
      r_af         <= (w_count_nxt >= AF_C);
      r_ae         <= (w_count_nxt <= AE_C);
      r_dout_valid <= w_rd_acc;
      r_ovf        <= wr_en & r_full;
      r_udf        <= rd_en & r_empty;
    end
  end

  // FWFT presents the head word combinationally from the array.
  assign dout         = FWFT ? r_mem[r_rd_ptr] : r_dout;
  assign dout_valid   = FWFT ? ~r_empty : r_dout_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign data_count   = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: one standard-mode and one FWFT instance share directed
// stimulus; read data is checked by per-instance scoreboards, flags every cycle.
module tb_fifo_sync;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
  logic [4:0]    s_cnt, f_cnt;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] exp_q_std[$];
  logic [DW-1:0] exp_q_fwft[$];
  int            m_count = 0;
  logic          m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;

  fifo_sync #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .data_count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference occupancy model; pushes expected words when a write is accepted
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_count <= 0;
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
      m_dv <= 1'b0;
      exp_q_std.delete();
      exp_q_fwft.delete();
    end else begin
      m_count <= m_count + ((wr_en && m_count != DEPTH) ? 1 : 0) - ((rd_en && m_count != 0) ? 1 : 0);
      m_ovf <= wr_en && (m_count == DEPTH);
      m_udf <= rd_en && (m_count == 0);
      m_dv <= rd_en && (m_count != 0);
      if (wr_en && m_count != DEPTH) begin
        exp_q_std.push_back(din);
        exp_q_fwft.push_back(din);
      end
    end
  end

  // flag/count monitor
  always @(negedge sys_clk) begin
    if (chk_en) begin
      logic [11:0] exp_s, exp_f;
      exp_s = {5'(m_count), m_count == DEPTH, m_count == 0, m_count >= 14, m_count <= 2,
               m_ovf, m_udf, m_dv};
      exp_f = exp_s;
      exp_f[0] = (m_count != 0);
      check("std_flags", {s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_dv}, exp_s);
      check("fwft_flags", {f_cnt, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_dv}, exp_f);
    end
  end

  // scoreboard: standard mode pops on dout_valid
  always @(negedge sys_clk) begin
    if (chk_en && s_dv === 1'b1) begin
      if (exp_q_std.size() == 0) check("std_unexpected_word", s_dout, 32'hFFFF_FFFF);
      else check("std_data", s_dout, exp_q_std.pop_front());
    end
  end

  // scoreboard: FWFT pops when the head is consumed
  always @(negedge sys_clk) begin
    if (chk_en && !sys_rst && rd_en && f_dv === 1'b1) begin
      if (exp_q_fwft.size() == 0) check("fwft_unexpected_word", f_dout, 32'hFFFF_FFFF);
      else check("fwft_data", f_dout, exp_q_fwft.pop_front());
    end
  end

  initial begin
    sys_rst = 1'b1; wr_en = 1'b1; din = 8'h11; rd_en = 1'b0;
    repeat (3) tick();
    check("rst_std_cnt", s_cnt, 0);
    check("rst_fwft_cnt", f_cnt, 0);
    check("rst_std_flags", {s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_dv}, 7'b0101000);
    check("rst_fwft_flags", {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_dv}, 7'b0101000);
    check("rst_std_dout", s_dout, 0);
    sys_rst = 1'b0; wr_en = 1'b0;
    chk_en = 1'b1;
    tick();

    // fill
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; din = DW'(i);
      tick();
      if (i == 1)  check("ae_at_2", s_ae, 1);
      if (i == 2)  check("ae_drop_at_3", s_ae, 0);
      if (i == 12) check("af_at_13", s_af, 0);
      if (i == 13) check("af_rise_at_14", f_af, 1);
    end
    check("full_after_16", {s_full, f_full}, 2'b11);
    check("count_16", s_cnt, 16);
    din = 8'hAA;
    tick();
    check("ovf_pulse", {s_ovf, f_ovf}, 2'b11);
    check("count_stays_16", f_cnt, 16);
    wr_en = 1'b0;
    tick();
    check("ovf_one_cycle", {s_ovf, f_ovf}, 2'b00);

    // drain
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      if (i == 0) check("fwft_head_0", f_dout, 8'h00);
      tick();
      if (i == 0) check("std_first_word", {s_dv, s_dout}, 9'h100);
    end
    check("empty_after_drain", {s_empty, f_empty}, 2'b11);
    tick();
    check("udf_pulse", {s_udf, f_udf}, 2'b11);
    check("std_dout_holds", s_dout, 8'h0F);
    rd_en = 1'b0;
    tick();

    // wrap: preload 5 then 40 cycles of write+read
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 8'hE0 + DW'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = DW'(i);
      tick();
      check("wrap_count", {s_cnt, f_cnt}, {5'd5, 5'd5});
    end
    wr_en = 1'b0;
    repeat (5) tick();
    rd_en = 1'b0;
    tick();

    // simultaneous write+read at full
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; din = 8'h30 + DW'(i);
      tick();
    end
    rd_en = 1'b1; din = 8'hBB;
    tick();
    check("wr_rd_full_count", s_cnt, 15);
    check("wr_rd_full_ovf", {s_ovf, f_ovf}, 2'b11);
    wr_en = 1'b0;
    repeat (15) tick();
    check("drained_again", f_empty, 1);

    // simultaneous write+read at empty
    wr_en = 1'b1; din = 8'h55;
    tick();
    check("wr_rd_empty_count", f_cnt, 1);
    check("wr_rd_empty_udf", {s_udf, f_udf}, 2'b11);
    wr_en = 1'b0;
    check("fwft_head_55", f_dout, 8'h55);
    tick();
    check("std_read_55", {s_dv, s_dout}, 9'h155);
    rd_en = 1'b0;
    tick();

    // reset mid-stream
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; din = 8'h90 + DW'(i);
      tick();
    end
    wr_en = 1'b0; sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("midrst_count", {s_cnt, f_cnt}, 10'd0);
    check("midrst_empty", {s_empty, f_empty}, 2'b11);
    wr_en = 1'b1; din = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    check("fwft_after_rst", f_dout, 8'h77);
    tick();
    rd_en = 1'b0;
    check("std_after_rst", {s_dv, s_dout}, 9'h177);
    repeat (2) tick();

    check("std_queue_drained", exp_q_std.size(), 0);
    check("fwft_queue_drained", exp_q_fwft.size(), 0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
